// File: rtl/hazard_controller.sv
// ============================================================================
// hazard_controller
// ----------------------------------------------------------------------------
// Pipeline hazard controller for the 5-stage MIPS core. It detects load-use
// hazards between the instruction in ID and a load in EX, handles beq/bne
// control hazards (resolved in EX), and freezes the pipeline while the data
// memory inserts wait states. It also keeps a saturating count of the cycles
// in which the PC was held, for performance tracking.
//
// Optional feature (compile-time macro BRANCH_PREDICT_NT_EN):
//   defined   -> predict-not-taken. Branches in ID cost nothing. A taken
//                branch in EX redirects the PC and flushes IF/ID and ID/EX.
//   undefined -> stall-on-branch. A branch in ID holds the PC for one cycle
//                and flushes IF/ID. The branch is then resolved in EX.
//
// Parameters:
//   REG_ADDR_W    register-specifier width
//   ADDR_W        PC / branch-offset width
//   LOAD_LATENCY  bubbles inserted per load-use hazard (>=1)
//   CNT_W         stall-cycle counter width
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   rs_id, rt_id        source specifiers of the instruction in ID
//   rs_used_id          ID instruction reads rs
//   rt_used_id          ID instruction reads rt
//   rt_ex               destination of the instruction in EX
//   mem_read_ex         EX instruction is a load
//   beq_id, bne_id      branch decoded in ID
//   beq_ex, bne_ex      branch in EX
//   zero_ex             ALU zero flag in EX
//   offset_ex           branch offset carried in ID/EX
//   mem_busy            data memory not ready this cycle
//   hold_pc             PC keeps its value
//   hold_if_id          IF/ID keeps its value
//   flush_if_id         IF/ID loads a NOP
//   flush_id_ex         ID/EX loads a NOP (bubble)
//   stall_all           freeze ID/EX, EX/MEM and MEM/WB
//   take_branch         PC <= PC + pc_offset
//   pc_offset           offset_ex when take_branch, else 0
//   stall_cycles        saturating count of cycles with hold_pc = 1
// ============================================================================
module hazard_controller #(
  parameter int REG_ADDR_W   = 5,
  parameter int ADDR_W       = 32,
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs_id,
  input  logic [REG_ADDR_W-1:0] rt_id,
  input  logic                  rs_used_id,
  input  logic                  rt_used_id,
  input  logic [REG_ADDR_W-1:0] rt_ex,
  input  logic                  mem_read_ex,
  input  logic                  beq_id,
  input  logic                  bne_id,
  input  logic                  beq_ex,
  input  logic                  bne_ex,
  input  logic                  zero_ex,
  input  logic [ADDR_W-1:0]     offset_ex,
  input  logic                  mem_busy,
  output logic                  hold_pc,
  output logic                  hold_if_id,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  stall_all,
  output logic                  take_branch,
  output logic [ADDR_W-1:0]     pc_offset,
  output logic [CNT_W-1:0]      stall_cycles
);

  // Width of the remaining-bubble counter; it only needs to hold
  // LOAD_LATENCY-1, but is kept at least one bit wide.
  localparam int LAT_W = (LOAD_LATENCY > 1) ? $clog2(LOAD_LATENCY) : 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    BR_WAIT  = 2'd2,
    MEM_WAIT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  state_e           ret_state_q, ret_state_d;
  state_e           eff_state;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic             load_use;
  logic             ex_taken;
  logic             br_id;

  // Hazard terms. Register $0 is hard-wired to zero, so a load into it can
  // never create a real dependency.
  assign load_use = mem_read_ex && (rt_ex != '0) &&
                    ((rs_used_id && (rs_id == rt_ex)) ||
                     (rt_used_id && (rt_id == rt_ex)));
  assign ex_taken = (beq_ex && zero_ex) || (bne_ex && !zero_ex);
  assign br_id    = beq_id || bne_id;

  // Once memory is ready again, MEM_WAIT behaves exactly like the state it
  // interrupted, so the rest of the decoder only ever sees RUN, LD_STALL or
  // BR_WAIT.
  assign eff_state = (state_q == MEM_WAIT) ? ret_state_q : state_q;

  // Next-state and output decode. Every output starts at 0; the bubble
  // counter and return state are held unless explicitly updated.
  always_comb begin
    state_d     = state_q;
    ret_state_d = ret_state_q;
    cnt_d       = cnt_q;
    hold_pc     = 1'b0;
    hold_if_id  = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    stall_all   = 1'b0;
    take_branch = 1'b0;
    pc_offset   = '0;

    if (mem_busy) begin
      // Whole pipeline frozen; the interrupted state is remembered once so
      // a long wait does not overwrite it with MEM_WAIT.
      stall_all  = 1'b1;
      hold_pc    = 1'b1;
      hold_if_id = 1'b1;
      state_d    = MEM_WAIT;
      if (state_q != MEM_WAIT) begin
        ret_state_d = state_q;
      end
    end else begin
      case (eff_state)
        RUN: begin
          state_d = RUN;
`ifdef BRANCH_PREDICT_NT_EN
          // Mispredicted (taken) branch: the instructions in IF/ID and
          // ID/EX are wrong-path, so any load-use they show is ignored.
          if (ex_taken) begin
            take_branch = 1'b1;
            pc_offset   = offset_ex;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (load_use) begin
            hold_pc     = 1'b1;
            hold_if_id  = 1'b1;
            flush_id_ex = 1'b1;
            if (LOAD_LATENCY > 1) begin
              state_d = LD_STALL;
              cnt_d   = LAT_W'(LOAD_LATENCY - 1);
            end
          end
`else
          // A load ahead of a dependent branch is serviced first; the
          // branch stays in ID and is handled once the stall ends.
          if (load_use) begin
            hold_pc     = 1'b1;
            hold_if_id  = 1'b1;
            flush_id_ex = 1'b1;
            if (LOAD_LATENCY > 1) begin
              state_d = LD_STALL;
              cnt_d   = LAT_W'(LOAD_LATENCY - 1);
            end
          end else if (br_id) begin
            hold_pc     = 1'b1;
            flush_if_id = 1'b1;
            state_d     = BR_WAIT;
          end
`endif
        end

        LD_STALL: begin
          // EX holds a bubble here, so load_use is not looked at again.
          hold_pc     = 1'b1;
          hold_if_id  = 1'b1;
          flush_id_ex = 1'b1;
          cnt_d       = cnt_q - LAT_W'(1);
          if (cnt_q == LAT_W'(1)) begin
            state_d = RUN;
          end else begin
            state_d = LD_STALL;
          end
        end

        BR_WAIT: begin
          // The branch has reached EX and is resolved in this one cycle.
          take_branch = ex_taken;
          if (ex_taken) begin
            pc_offset = offset_ex;
          end
          state_d = RUN;
        end

        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // Performance counter: counts held-PC cycles and sticks at all-ones.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (hold_pc && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      ret_state_q    <= RUN;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      ret_state_q    <= ret_state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_controller.sv
// ============================================================================
// tb_hazard_controller
// ----------------------------------------------------------------------------
// Directed bench for hazard_controller. Three instances share one set of
// inputs:
//   a : LOAD_LATENCY=1, CNT_W=16
//   b : LOAD_LATENCY=3, CNT_W=16
//   c : LOAD_LATENCY=1, CNT_W=2   (stall counter saturates at 3)
// Control outputs are packed as
//   {hold_pc, hold_if_id, flush_if_id, flush_id_ex, stall_all, take_branch}.
// ============================================================================
module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs_id, rt_id, rt_ex;
  logic        rs_used_id, rt_used_id, mem_read_ex;
  logic        beq_id, bne_id, beq_ex, bne_ex, zero_ex, mem_busy;
  logic [31:0] offset_ex;

  logic        hp_a, hi_a, fi_a, fe_a, sa_a, tb_a;
  logic        hp_b, hi_b, fi_b, fe_b, sa_b, tb_b;
  logic        hp_c, hi_c, fi_c, fe_c, sa_c, tb_c;
  logic [31:0] off_a, off_b, off_c;
  logic [15:0] sc_a, sc_b;
  logic [1:0]  sc_c;

  logic [5:0]  ctl_a, ctl_b, ctl_c;
  assign ctl_a = {hp_a, hi_a, fi_a, fe_a, sa_a, tb_a};
  assign ctl_b = {hp_b, hi_b, fi_b, fe_b, sa_b, tb_b};
  assign ctl_c = {hp_c, hi_c, fi_c, fe_c, sa_c, tb_c};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_controller #(.LOAD_LATENCY(1), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .rs_id(rs_id), .rt_id(rt_id),
    .rs_used_id(rs_used_id), .rt_used_id(rt_used_id), .rt_ex(rt_ex),
    .mem_read_ex(mem_read_ex), .beq_id(beq_id), .bne_id(bne_id),
    .beq_ex(beq_ex), .bne_ex(bne_ex), .zero_ex(zero_ex),
    .offset_ex(offset_ex), .mem_busy(mem_busy),
    .hold_pc(hp_a), .hold_if_id(hi_a), .flush_if_id(fi_a),
    .flush_id_ex(fe_a), .stall_all(sa_a), .take_branch(tb_a),
    .pc_offset(off_a), .stall_cycles(sc_a)
  );

  hazard_controller #(.LOAD_LATENCY(3), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .rs_id(rs_id), .rt_id(rt_id),
    .rs_used_id(rs_used_id), .rt_used_id(rt_used_id), .rt_ex(rt_ex),
    .mem_read_ex(mem_read_ex), .beq_id(beq_id), .bne_id(bne_id),
    .beq_ex(beq_ex), .bne_ex(bne_ex), .zero_ex(zero_ex),
    .offset_ex(offset_ex), .mem_busy(mem_busy),
    .hold_pc(hp_b), .hold_if_id(hi_b), .flush_if_id(fi_b),
    .flush_id_ex(fe_b), .stall_all(sa_b), .take_branch(tb_b),
    .pc_offset(off_b), .stall_cycles(sc_b)
  );

  hazard_controller #(.LOAD_LATENCY(1), .CNT_W(2)) u_c (
    .clk(clk), .rst_n(rst_n), .rs_id(rs_id), .rt_id(rt_id),
    .rs_used_id(rs_used_id), .rt_used_id(rt_used_id), .rt_ex(rt_ex),
    .mem_read_ex(mem_read_ex), .beq_id(beq_id), .bne_id(bne_id),
    .beq_ex(beq_ex), .bne_ex(bne_ex), .zero_ex(zero_ex),
    .offset_ex(offset_ex), .mem_busy(mem_busy),
    .hold_pc(hp_c), .hold_if_id(hi_c), .flush_if_id(fi_c),
    .flush_id_ex(fe_c), .stall_all(sa_c), .take_branch(tb_c),
    .pc_offset(off_c), .stall_cycles(sc_c)
  );

  // Drives one cycle's inputs on the falling edge, then lets the
  // combinational outputs settle before any check is made.
  task automatic applyStimulus(
    input logic [4:0]  rs, input logic rsu,
    input logic [4:0]  rt, input logic rtu,
    input logic [4:0]  rtex, input logic mr,
    input logic        bqid, input logic bnid,
    input logic        bqex, input logic bnex, input logic z,
    input logic [31:0] off, input logic mb
  );
    @(negedge clk);
    rs_id       = rs;   rs_used_id = rsu;
    rt_id       = rt;   rt_used_id = rtu;
    rt_ex       = rtex; mem_read_ex = mr;
    beq_id      = bqid; bne_id = bnid;
    beq_ex      = bqex; bne_ex = bnex; zero_ex = z;
    offset_ex   = off;  mem_busy = mb;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rs_id = '0; rt_id = '0; rt_ex = '0;
    rs_used_id = 1'b0; rt_used_id = 1'b0; mem_read_ex = 1'b0;
    beq_id = 1'b0; bne_id = 1'b0; beq_ex = 1'b0; bne_ex = 1'b0;
    zero_ex = 1'b0; offset_ex = '0; mem_busy = 1'b0;

    // Reset state
    #2;
    checkOutput("reset_ctl_a", 32'(ctl_a), 32'h00);
    checkOutput("reset_sc_a",  32'(sc_a),  32'd0);
    checkOutput("reset_sc_c",  32'(sc_c),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] load-use with rs, latency 1 and 3");
    applyStimulus(5'd2, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("lu_rs_ctl_a", 32'(ctl_a), 32'h34);
    checkOutput("lu_rs_ctl_b", 32'(ctl_b), 32'h34);
    checkOutput("lu_rs_off_a", off_a, 32'h0);
    idleCycle();
    checkOutput("lu_after_ctl_a", 32'(ctl_a), 32'h00);
    checkOutput("lu_after_sc_a",  32'(sc_a),  32'd1);
    checkOutput("lu3_bubble2_b",  32'(ctl_b), 32'h34);
    idleCycle();
    checkOutput("lu3_bubble3_b",  32'(ctl_b), 32'h34);
    checkOutput("lu3_sc2_b",      32'(sc_b),  32'd2);
    idleCycle();
    checkOutput("lu3_run_b",      32'(ctl_b), 32'h00);
    checkOutput("lu3_sc3_b",      32'(sc_b),  32'd3);

    $display("[TB] load-use boundaries");
    applyStimulus(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("lu_r0_ctl_a", 32'(ctl_a), 32'h00);
    applyStimulus(5'd7, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("lu_rs_unused_ctl_a", 32'(ctl_a), 32'h00);
    applyStimulus(5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("lu_rt_ctl_a", 32'(ctl_a), 32'h34);
    idleCycle();
    idleCycle();
    checkOutput("lu_rt_sc_a", 32'(sc_a), 32'd2);

`ifndef BRANCH_PREDICT_NT_EN
    $display("[TB] stall-on-branch");
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("beq_id_ctl_a", 32'(ctl_a), 32'h28);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0);
    checkOutput("beq_ex_ctl_a", 32'(ctl_a), 32'h01);
    checkOutput("beq_ex_off_a", off_a, 32'h10);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("bne_id_ctl_a", 32'(ctl_a), 32'h28);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 1'b0);
    checkOutput("bne_nt_ctl_a", 32'(ctl_a), 32'h00);
    checkOutput("bne_nt_off_a", off_a, 32'h0);

    $display("[TB] memory wait during branch resolution");
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("mw_beq_id_ctl_a", 32'(ctl_a), 32'h28);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h44, 1'b1);
      checkOutput("mw_busy_ctl_a", 32'(ctl_a), 32'h32);
      checkOutput("mw_busy_off_a", off_a, 32'h0);
    end
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h44, 1'b0);
    checkOutput("mw_resolve_ctl_a", 32'(ctl_a), 32'h01);
    checkOutput("mw_resolve_off_a", off_a, 32'h44);
    idleCycle();
    checkOutput("mw_sc_a", 32'(sc_a), 32'd9);
    checkOutput("mw_sc_b", 32'(sc_b), 32'd13);
    checkOutput("sat_sc_c", 32'(sc_c), 32'd3);
`endif

    $display("[TB] memory wait outranks load-use");
    applyStimulus(5'd2, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("mb_lu_ctl_a", 32'(ctl_a), 32'h32);
    applyStimulus(5'd2, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("mb_lu_after_ctl_a", 32'(ctl_a), 32'h34);
    idleCycle();
    checkOutput("pre_reset_ldstall_b", 32'(ctl_b), 32'h34);

    $display("[TB] asynchronous reset in LD_STALL");
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_ctl_b", 32'(ctl_b), 32'h00);
    checkOutput("mid_reset_sc_b",  32'(sc_b),  32'd0);
    checkOutput("mid_reset_sc_a",  32'(sc_a),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idleCycle();
    checkOutput("post_reset_ctl_b", 32'(ctl_b), 32'h00);

`ifdef BRANCH_PREDICT_NT_EN
    $display("[TB] predict-not-taken");
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("nt_beq_id_ctl_a", 32'(ctl_a), 32'h00);
    applyStimulus(5'd2, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0);
    checkOutput("nt_taken_lu_ctl_a", 32'(ctl_a), 32'h0D);
    checkOutput("nt_taken_lu_ctl_b", 32'(ctl_b), 32'h0D);
    checkOutput("nt_taken_lu_off_a", off_a, 32'h10);
    idleCycle();
    checkOutput("nt_after_ctl_b", 32'(ctl_b), 32'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
